// File: rtl/branch_pkg.sv
// Shared types and constants for EX-stage branch resolution and the
// branch history table it trains.
package branch_pkg;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  typedef logic [1:0] bht_ctr_t;
  localparam bht_ctr_t BHT_RST = 2'b01;
  localparam bht_ctr_t BHT_MAX = 2'b11;
  localparam bht_ctr_t BHT_MIN = 2'b00;

  typedef enum logic {IDLE, FLUSH} br_state_e;

  // 2-bit saturating counter step
  function automatic bht_ctr_t bht_next(bht_ctr_t ctr, logic taken);
    bht_ctr_t res;
    res = ctr;
    if (taken) begin
      if (ctr != BHT_MAX) res = ctr + 2'b01;
    end else begin
      if (ctr != BHT_MIN) res = ctr - 2'b01;
    end
    return res;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Signal bundle between the pipeline (IF/EX/BRC side) and the branch
// resolve unit.
interface branch_resolve_unit_if
  import branch_pkg::*;
#(
  parameter int PC_W = 32
);
  // i_ex_valid qualifies every i_ex_* field in the same cycle; there is no
  // ready/backpressure, the unit resolves an EX op in the cycle it is valid.
  logic [PC_W-1:0] i_if_pc;
  logic            o_if_pred_taken;
  logic            i_ex_valid;
  logic            i_ex_is_branch;
  logic            i_ex_is_jump;
  logic [2:0]      i_ex_funct3;
  logic [PC_W-1:0] i_ex_pc;
  logic [PC_W-1:0] i_ex_target;
  logic            i_ex_pred_taken;
  logic            o_br_un;
  logic            i_br_less;
  logic            i_br_equal;
  logic            o_redirect;
  logic [PC_W-1:0] o_redirect_pc;
  logic            o_flush;
  logic [31:0]     o_br_cnt;
  logic [31:0]     o_mispred_cnt;
  br_state_e       dbg_state;

  modport master (
    output i_if_pc, i_ex_valid, i_ex_is_branch, i_ex_is_jump, i_ex_funct3,
           i_ex_pc, i_ex_target, i_ex_pred_taken, i_br_less, i_br_equal,
    input  o_if_pred_taken, o_br_un, o_redirect, o_redirect_pc, o_flush,
           o_br_cnt, o_mispred_cnt, dbg_state
  );

  modport slave (
    input  i_if_pc, i_ex_valid, i_ex_is_branch, i_ex_is_jump, i_ex_funct3,
           i_ex_pc, i_ex_target, i_ex_pred_taken, i_br_less, i_br_equal,
    output o_if_pred_taken, o_br_un, o_redirect, o_redirect_pc, o_flush,
           o_br_cnt, o_mispred_cnt, dbg_state
  );

endinterface

// File: rtl/branch_history_table.sv
// Array of 2-bit saturating counters: combinational read port for IF,
// single saturating update port for EX.
module branch_history_table
  import branch_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output bht_ctr_t         rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  bht_ctr_t mem [ENTRIES];

  // Read is straight from the registers, so a same-cycle update is not seen.
  assign rd_ctr = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) mem[i] <= BHT_RST;
    end else if (wr_en) begin
      mem[wr_idx] <= bht_next(mem[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: funct3 decode, outcome vs prediction check,
// registered redirect/flush, BHT training and performance counters.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int BHT_ENTRIES = 64,
  parameter int PC_W        = 32
) (
  input logic                  i_clk,
  input logic                  i_reset,
  branch_resolve_unit_if.slave bus
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  br_state_e       state_q, state_d;
  logic            f3_legal;
  logic            actual_taken;
  logic            in_idle;
  logic            jump_ev;
  logic            branch_ev;
  logic            mispred;
  logic            redirect_d;
  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] target_d;
  logic            redirect_q;
  logic [PC_W-1:0] redirect_pc_q;
  logic [31:0]     br_cnt_q;
  logic [31:0]     mispred_cnt_q;
  bht_ctr_t        if_ctr;
  logic            unused_if_pc;

  assign f3_legal = (bus.i_ex_funct3 != 3'b010) && (bus.i_ex_funct3 != 3'b011);

  always_comb begin
    actual_taken = 1'b0;
    case (bus.i_ex_funct3)
      BR_BEQ:           actual_taken = bus.i_br_equal;
      BR_BNE:           actual_taken = !bus.i_br_equal;
      BR_BLT, BR_BLTU:  actual_taken = bus.i_br_less;
      BR_BGE, BR_BGEU:  actual_taken = !bus.i_br_less;
      default:          actual_taken = 1'b0;
    endcase
  end

  assign bus.o_br_un = (bus.i_ex_funct3 == BR_BLTU) || (bus.i_ex_funct3 == BR_BGEU);

  // Jump wins when both type flags are set; FLUSH masks all EX activity.
  assign in_idle    = (state_q == IDLE);
  assign jump_ev    = in_idle && bus.i_ex_valid && bus.i_ex_is_jump;
  assign branch_ev  = in_idle && bus.i_ex_valid && bus.i_ex_is_branch &&
                      !bus.i_ex_is_jump && f3_legal;
  assign mispred    = branch_ev && (actual_taken != bus.i_ex_pred_taken);
  assign redirect_d = jump_ev || mispred;
  assign seq_pc     = bus.i_ex_pc + PC_W'(4);
  assign target_d   = (jump_ev || actual_taken) ? bus.i_ex_target : seq_pc;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (redirect_d) state_d = FLUSH;
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q       <= IDLE;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      redirect_q <= redirect_d;
      if (redirect_d) redirect_pc_q <= target_d;
      if (branch_ev)  br_cnt_q      <= br_cnt_q + 32'd1;
      if (mispred)    mispred_cnt_q <= mispred_cnt_q + 32'd1;
    end
  end

  branch_history_table #(
    .ENTRIES (BHT_ENTRIES),
    .IDX_W   (IDX_W)
  ) u_bht (
    .clk      (i_clk),
    .rst_n    (i_reset),
    .rd_idx   (bus.i_if_pc[IDX_W+1:2]),
    .rd_ctr   (if_ctr),
    .wr_en    (branch_ev),
    .wr_idx   (bus.i_ex_pc[IDX_W+1:2]),
    .wr_taken (actual_taken)
  );

  assign unused_if_pc = ^{bus.i_if_pc[PC_W-1:IDX_W+2], bus.i_if_pc[1:0], if_ctr[0]};

  assign bus.o_if_pred_taken = if_ctr[1];
  assign bus.o_redirect      = redirect_q;
  assign bus.o_flush         = redirect_q;
  assign bus.o_redirect_pc   = redirect_pc_q;
  assign bus.o_br_cnt        = br_cnt_q;
  assign bus.o_mispred_cnt   = mispred_cnt_q;
  assign bus.dbg_state       = state_q;

endmodule
